// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt-pending collector.
package irq_pkg;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_t;

  localparam int IRQ_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/priority_encoder.sv
// Highest-index-wins priority encoder; valid is high when any input bit is set.
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [ID_W-1:0]  out,
  output logic             valid
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        out   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt-pending collector: edge-detects request lines, latches pending
// bits, masks them into a priority encoder and presents the winner as a
// registered valid/ready transaction. Acknowledge clears the served bit.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int WIDTH = IRQ_WIDTH_DEFAULT,
  parameter int ID_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             clr_all,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [WIDTH-1:0] pending
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] ack_bit;
  logic [WIDTH-1:0] pending_nxt;
  logic [ID_W-1:0]  enc_id;
  logic             enc_any;
  logic             hs;
  irq_state_t       state;

  assign rise = irq_in & ~prev;
  assign sel  = pending & mask;
  assign hs   = irq_valid & irq_ready;

  // Bit being acknowledged this edge (none without a handshake).
  assign ack_bit = hs ? (WIDTH'(1) << irq_id) : '0;

  // Set from a rise outranks the acknowledge clear on the same bit.
  assign pending_nxt = (pending & ~ack_bit) | rise;

  priority_encoder #(
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) u_enc (
    .in    (sel),
    .out   (enc_id),
    .valid (enc_any)
  );

  // Edge-detect history; keeps tracking during clr_all so held lines stay quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) prev <= '0;
    else        prev <= irq_in;
  end

  // Pending register: clr_all, then set from rise, then clear on acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n)       pending <= '0;
    else if (clr_all) pending <= '0;
    else              pending <= pending_nxt;
  end

  // Presentation FSM with registered id/valid; a presented id is never retracted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IRQ_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else if (clr_all) begin
      state     <= IRQ_IDLE;
      irq_valid <= 1'b0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (enc_any) begin
            irq_id    <= enc_id;
            irq_valid <= 1'b1;
            state     <= IRQ_PRESENT;
          end
        end
        IRQ_PRESENT: begin
          if (hs) begin
            irq_valid <= 1'b0;
            state     <= IRQ_IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: a behavioural model predicts the
// outputs after every rising edge, a negedge monitor compares the DUT.
module tb_irq_pending_ctrl;

  localparam int WIDTH = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] irq_in;
  logic [WIDTH-1:0] mask;
  logic             clr_all;
  logic [ID_W-1:0]  irq_id;
  logic             irq_valid;
  logic             irq_ready;
  logic [WIDTH-1:0] pending;

  irq_pending_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .irq_id    (irq_id),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    int         id;
    logic [7:0] p;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   presented = 0;

  // Reference model state: set of pending requests and the open presentation.
  bit m_pend[WIDTH];
  bit m_prev[WIDTH];
  bit m_valid = 0;
  int m_id = 0;

  always @(posedge clk) begin
    bit   rise[WIDTH];
    bit   hs;
    int   best;
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
      end
      m_valid = 0;
      m_id    = 0;
    end else begin
      hs   = m_valid && irq_ready;
      best = -1;
      for (int i = WIDTH - 1; i >= 0; i--)
        if (best < 0 && m_pend[i] && mask[i]) best = i;
      for (int i = 0; i < WIDTH; i++) rise[i] = irq_in[i] && !m_prev[i];
      if (clr_all) begin
        for (int i = 0; i < WIDTH; i++) m_pend[i] = 0;
        m_valid = 0;
      end else begin
        if (hs && !rise[m_id]) m_pend[m_id] = 0;
        for (int i = 0; i < WIDTH; i++) if (rise[i]) m_pend[i] = 1;
        if (m_valid) begin
          if (hs) m_valid = 0;
        end else if (best >= 0) begin
          m_valid = 1;
          m_id    = best;
        end
      end
      for (int i = 0; i < WIDTH; i++) m_prev[i] = irq_in[i];
    end
    e.v = m_valid;
    e.id = m_id;
    e.p = '0;
    for (int i = 0; i < WIDTH; i++) e.p[i] = m_pend[i];
    q.push_back(e);
  end

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (irq_valid !== e.v) begin
        errors++;
        $display("FAIL valid: got %b expected %b at %0t", irq_valid, e.v, $time);
      end
      checks++;
      if (pending !== e.p) begin
        errors++;
        $display("FAIL pending: got %h expected %h at %0t", pending, e.p, $time);
      end
      if (e.v) begin
        presented++;
        checks++;
        if (int'(irq_id) != e.id) begin
          errors++;
          $display("FAIL irq_id: got %0d expected %0d at %0t", irq_id, e.id, $time);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = 8'hFF; clr_all = 1'b0; irq_ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);                                   // idle after reset

    irq_in = 8'h04; cyc(1); irq_in = 8'h00;   // single pulse, held presentation
    cyc(7);
    irq_ready = 1'b1; cyc(2); irq_ready = 1'b0;
    cyc(2);

    irq_ready = 1'b1;                         // 6, 4, 1 back to back
    irq_in = 8'h52; cyc(1); irq_in = 8'h00;
    cyc(10);
    irq_ready = 1'b0;

    mask = 8'h0F;                             // masked bit stays pending
    irq_in = 8'h88; cyc(1); irq_in = 8'h00;
    cyc(3);
    irq_ready = 1'b1; cyc(1); irq_ready = 1'b0;
    cyc(4);
    mask = 8'hFF; cyc(3);
    irq_ready = 1'b1; cyc(1); irq_ready = 1'b0;
    cyc(2);

    irq_in = 8'h20; cyc(1); irq_in = 8'h00;   // no preemption of presented id
    cyc(3);
    irq_in = 8'h80; cyc(1); irq_in = 8'h00;
    cyc(3);
    irq_ready = 1'b1; cyc(1); irq_ready = 1'b0;
    cyc(3);
    irq_ready = 1'b1; cyc(1); irq_ready = 1'b0;
    cyc(2);

    irq_in = 8'h20; cyc(1); irq_in = 8'h00;   // re-rise during acknowledge
    cyc(3);
    irq_in = 8'h20; irq_ready = 1'b1; cyc(1);
    irq_in = 8'h00; irq_ready = 1'b0;
    cyc(3);
    irq_ready = 1'b1; cyc(1); irq_ready = 1'b0;
    cyc(2);

    irq_in = 8'h21; cyc(1); irq_in = 8'h01;   // clr_all with held-high line
    cyc(3);
    clr_all = 1'b1; cyc(1); clr_all = 1'b0;
    cyc(3);
    irq_in = 8'h00; cyc(1);
    irq_in = 8'h21; cyc(1); irq_in = 8'h01;   // reset mid-presentation
    cyc(3);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    cyc(3);
    irq_in = 8'h00; cyc(2);

    for (int k = 0; k < 3000; k++) begin
      irq_in    = WIDTH'($urandom & $urandom & $urandom);
      irq_ready = ($urandom_range(0, 2) != 0);
      clr_all   = ($urandom_range(0, 60) == 0);
      rst_n     = ($urandom_range(0, 150) != 0);
      if ($urandom_range(0, 20) == 0) mask = WIDTH'($urandom | $urandom);
      cyc(1);
    end
    rst_n = 1'b1; clr_all = 1'b0; irq_in = '0; irq_ready = 1'b1; mask = 8'hFF;
    cyc(12);

    checks++;
    if (presented == 0) begin
      errors++;
      $display("FAIL activity: presentations seen %0d required nonzero", presented);
    end
    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL drain: queue depth %0d required at most 1", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
